// File: rtl/wb_mux_wdt.sv
// wb_mux_wdt: single-master to NUM_SLAVES Wishbone B4 address decoder/mux.
// It registers the address decode, so each transfer takes one more cycle
// than a direct connection. Overlapping windows go to the lowest-index
// slave. Unmapped addresses are error-terminated. An optional per-transfer
// bus watchdog error-terminates a slave that never answers.
// Optional feature macro: WB_MUX_WDT_TIMEOUT_EN. When it is defined, the
// watchdog and its timeout-to-ERR path are built.

module wb_mux_wdt #(
    parameter int                          NUM_SLAVES = 4,
    parameter int                          AW         = 32,
    parameter int                          DW         = 32,
    parameter logic [NUM_SLAVES*AW-1:0]    MATCH_ADDR = {32'hb3000000, 32'hb2000000,
                                                         32'hb1000000, 32'hb0000000},
    parameter logic [NUM_SLAVES*AW-1:0]    MATCH_MASK = {32'hffff0000, 32'hffff0000,
                                                         32'hff000000, 32'hff000000},
    parameter int                          TIMEOUT    = 255,
    localparam int                         SW         = DW / 8
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [AW-1:0]            wbm_adr_i,
    input  logic [DW-1:0]            wbm_dat_i,
    input  logic [SW-1:0]            wbm_sel_i,
    input  logic                     wbm_we_i,
    input  logic                     wbm_cyc_i,
    input  logic                     wbm_stb_i,
    input  logic [2:0]               wbm_cti_i,
    input  logic [1:0]               wbm_bte_i,
    output logic [DW-1:0]            wbm_dat_o,
    output logic                     wbm_ack_o,
    output logic                     wbm_err_o,
    output logic                     wbm_rty_o,
    output logic [NUM_SLAVES*AW-1:0] wbs_adr_o,
    output logic [NUM_SLAVES*DW-1:0] wbs_dat_o,
    output logic [NUM_SLAVES*SW-1:0] wbs_sel_o,
    output logic [NUM_SLAVES-1:0]    wbs_we_o,
    output logic [NUM_SLAVES-1:0]    wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]    wbs_stb_o,
    output logic [NUM_SLAVES*3-1:0]  wbs_cti_o,
    output logic [NUM_SLAVES*2-1:0]  wbs_bte_o,
    input  logic [NUM_SLAVES*DW-1:0] wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]    wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]    wbs_err_i,
    input  logic [NUM_SLAVES-1:0]    wbs_rty_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_ERR    = 2'b10
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [NUM_SLAVES-1:0]   sel_r;
    logic [NUM_SLAVES-1:0]   sel_nxt_s;
    logic [NUM_SLAVES-1:0]   hit_s;
    logic [NUM_SLAVES-1:0]   match_s;
    logic [DW-1:0]           slv_dat_s;
    logic                    slv_ack_s;
    logic                    slv_err_s;
    logic                    slv_rty_s;
    logic                    term_s;
    logic                    burst_s;

    // Request fields go to every slave; only cyc/stb are steered.
    assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
    assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
    assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};
    assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}};
    assign wbs_cti_o = {NUM_SLAVES{wbm_cti_i}};
    assign wbs_bte_o = {NUM_SLAVES{wbm_bte_i}};

    // Compare the address against every window (hits may overlap).
    always_comb begin
        hit_s = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hit_s[i] = ((wbm_adr_i & MATCH_MASK[i*AW +: AW]) ==
                        (MATCH_ADDR[i*AW +: AW] & MATCH_MASK[i*AW +: AW]));
        end
    end

    // Keep only the lowest-index hit (isolate the least significant set bit).
    assign match_s = hit_s & (~hit_s + NUM_SLAVES'(1));

    // One-hot mux of the selected slave's response lines.
    always_comb begin
        slv_dat_s = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            slv_dat_s = slv_dat_s | (wbs_dat_i[i*DW +: DW] & {DW{sel_r[i]}});
        end
        slv_ack_s = |(sel_r & wbs_ack_i);
        slv_err_s = |(sel_r & wbs_err_i);
        slv_rty_s = |(sel_r & wbs_rty_i);
    end

    // A beat terminates on any slave response while the strobe is high.
    assign term_s = wbm_stb_i & (slv_ack_s | slv_err_s | slv_rty_s);

    // Classify the cycle type: only constant-address and incrementing
    // bursts keep the slave selected after a terminated beat.
    always_comb begin
        case (wbm_cti_i)
            3'b001, 3'b010: burst_s = 1'b1;
            default:        burst_s = 1'b0;
        endcase
    end

`ifdef WB_MUX_WDT_TIMEOUT_EN
    localparam int               WDT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TIMEOUT - 1);

    logic [WDT_W-1:0] wdt_r;
    logic             wdt_clr_s;
    logic             wdt_inc_s;
    logic             wdt_exp_s;

    // The last stalled cycle the watchdog allows before error termination.
    assign wdt_exp_s = (wdt_r == WDT_LAST);

    // Watchdog counter: counts stalled strobe cycles of the current beat.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wdt_r <= '0;
        end else if (wdt_clr_s) begin
            wdt_r <= '0;
        end else if (wdt_inc_s) begin
            wdt_r <= wdt_r + WDT_W'(1);
        end else begin
            wdt_r <= wdt_r;
        end
    end
`else
    // With no watchdog, TIMEOUT has no effect on the logic.
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT > 32'sd0);
`endif

    // Next-state logic for the state and the registered slave select.
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
`ifdef WB_MUX_WDT_TIMEOUT_EN
        wdt_clr_s   = 1'b0;
        wdt_inc_s   = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    sel_nxt_s = match_s;
`ifdef WB_MUX_WDT_TIMEOUT_EN
                    wdt_clr_s = 1'b1;
`endif
                    if (|match_s) begin
                        state_nxt_s = ST_ACTIVE;
                    end else begin
                        state_nxt_s = ST_ERR;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (!wbm_cyc_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (term_s) begin
`ifdef WB_MUX_WDT_TIMEOUT_EN
                    wdt_clr_s = 1'b1;
`endif
                    if (burst_s && !slv_err_s && !slv_rty_s) begin
                        state_nxt_s = ST_ACTIVE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (wbm_stb_i) begin
`ifdef WB_MUX_WDT_TIMEOUT_EN
                    if (wdt_exp_s) begin
                        state_nxt_s = ST_ERR;
                    end else begin
                        wdt_inc_s   = 1'b1;
                        state_nxt_s = ST_ACTIVE;
                    end
`else
                    state_nxt_s = ST_ACTIVE;
`endif
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            ST_ERR: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and slave-select registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r <= ST_IDLE;
            sel_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            sel_r   <= sel_nxt_s;
        end
    end

    // Steer cyc/stb and the master response from the current state.
    always_comb begin
        wbs_cyc_o = '0;
        wbs_stb_o = '0;
        wbm_dat_o = '0;
        wbm_ack_o = 1'b0;
        wbm_err_o = 1'b0;
        wbm_rty_o = 1'b0;
        case (state_r)
            ST_ACTIVE: begin
                wbs_cyc_o = sel_r & {NUM_SLAVES{wbm_cyc_i}};
                wbs_stb_o = sel_r & {NUM_SLAVES{wbm_stb_i}};
                wbm_dat_o = slv_dat_s;
                wbm_ack_o = slv_ack_s;
                wbm_err_o = slv_err_s;
                wbm_rty_o = slv_rty_s;
            end
            ST_ERR: begin
                wbm_err_o = 1'b1;
            end
            default: begin
                wbm_err_o = 1'b0;
            end
        endcase
    end

endmodule
